// File: rtl/instr_issuer_if.sv
// Issuer bus bundle: program-memory read port plus the
// instruction bus driven towards the decoder.
interface instr_issuer_if #(
  parameter int PC_W = 8
);
  logic            pmem_rd_en;
  logic [PC_W-1:0] pmem_addr;
  logic [7:0]      pmem_data;
  logic [7:0]      instr;
  logic            instr_valid;

  modport master (
    output pmem_rd_en,
    output pmem_addr,
    input  pmem_data,
    output instr,
    output instr_valid
  );

  modport slave (
    input  pmem_rd_en,
    input  pmem_addr,
    output pmem_data,
    input  instr,
    input  instr_valid
  );
endinterface

// File: rtl/instr_issuer.sv
// Instruction fetch/issue sequencer: fetches bytes from program
// memory, holds each on the decoder bus, pads with NOP bubbles.
module instr_issuer #(
  parameter int         PC_W      = 8,
  parameter int         ROM_HOLD  = 4,
  parameter int         RMOV_HOLD = 2,
  parameter logic [7:0] NOP_CODE  = 8'h80
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  input  logic            stall,
  instr_issuer_if.master  bus,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  localparam int HOLD_MAX =
    (ROM_HOLD > RMOV_HOLD) ? ROM_HOLD : RMOV_HOLD;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_ld;
  logic [7:0]        ir_q, ir_d;
  logic              rd_en_q, rd_en_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [7:0]        instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              op_rom, op_rmov, op_halt;

  assign op_rom  = bus.pmem_data[7:5] == 3'b001;
  assign op_rmov = bus.pmem_data[7:5] == 3'b010;
  assign op_halt = bus.pmem_data[7:5] == 3'b111;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      hold_q   <= '0;
      ir_q     <= NOP_CODE;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      instr_q  <= NOP_CODE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      ir_q     <= ir_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    hold_ld = HOLD_W'(1);
    unique case (1'b1)
      op_rom:  hold_ld = HOLD_W'(ROM_HOLD);
      op_rmov: hold_ld = HOLD_W'(RMOV_HOLD);
      default: hold_ld = HOLD_W'(1);
    endcase
  end

  // A fetch leaves FETCH only once its read strobe has been on the bus.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_en_q) state_d = S_LATCH;
      end
      S_LATCH: begin
        ir_d = bus.pmem_data;
        if (op_halt) begin
          state_d = S_HALT;
        end else begin
          hold_d  = hold_ld;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          if (hold_q == HOLD_W'(1)) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Leaving ISSUE prefetches at once so only two bubbles separate issues.
  always_comb begin
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    instr_d  = NOP_CODE;
    valid_d  = 1'b0;
    busy_d   = state_d inside {S_FETCH, S_LATCH, S_ISSUE};
    halted_d = state_d == S_HALT;
    if (state_d == S_FETCH &&
        (state_q == S_ISSUE ||
         (state_q == S_FETCH && !stall))) begin
      rd_en_d = 1'b1;
      addr_d  = pc_d;
    end
    if (state_d == S_ISSUE) begin
      instr_d = ir_d;
      valid_d = 1'b1;
    end
  end

  assign bus.pmem_rd_en  = rd_en_q;
  assign bus.pmem_addr   = addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign pc              = pc_q;
  assign busy            = busy_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: directed program scenarios plus randomized
// programs/stalls checked every cycle against a phase-level model.
module tb_instr_issuer;

  localparam logic [7:0] NOP = 8'h80;
  localparam int P_IDLE = 0;
  localparam int P_PRE  = 1;
  localparam int P_REQ  = 2;
  localparam int P_DATA = 3;
  localparam int P_ISS  = 4;
  localparam int P_HALT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] start_pc = 8'h00;
  logic [7:0] pc;
  logic       busy, halted;
  logic [7:0] pm_data;
  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] v_log[$];
  logic [7:0] addr_log[$];
  int         stall_rd = 0;

  int         ph = P_IDLE;
  logic [7:0] m_pc = 8'h00;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_ir = NOP;
  int         left = 0;

  instr_issuer_if #(.PC_W(8)) bus ();

  instr_issuer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .start_pc (start_pc),
    .stall    (stall),
    .bus      (bus),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.pmem_rd_en) pm_data <= mem[bus.pmem_addr];
  assign bus.pmem_data = pm_data;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic int hold_of(input logic [7:0] b);
    case (b[7:5])
      3'b001:  return 4;
      3'b010:  return 2;
      default: return 1;
    endcase
  endfunction

  // Model: each instruction is one prefetch-strobe cycle, one data
  // cycle, then hold_of() valid cycles stretched by stalls.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      ph = P_IDLE; m_pc = 0; m_addr = 0; m_ir = NOP;
    end else begin
      case (ph)
        P_IDLE, P_HALT:
          if (start) begin m_pc = start_pc; ph = P_PRE; end
        P_PRE:
          if (!stall) begin m_addr = m_pc; ph = P_REQ; end
        P_REQ: ph = P_DATA;
        P_DATA: begin
          m_ir = mem[m_pc];
          if (m_ir[7:5] == 3'b111) ph = P_HALT;
          else begin left = hold_of(m_ir); ph = P_ISS; end
        end
        P_ISS:
          if (!stall) begin
            if (left == 1) begin
              m_pc = 8'((int'(m_pc) + 1) % 256);
              m_addr = m_pc;
              ph = P_REQ;
            end else left--;
          end
        default: ph = P_IDLE;
      endcase
    end
  end

  initial forever begin
    logic [27:0] act, exp;
    @(posedge clk); #1;
    exp = {ph == P_REQ, m_addr,
           (ph == P_ISS) ? m_ir : NOP, ph == P_ISS, m_pc,
           ph inside {P_PRE, P_REQ, P_DATA, P_ISS},
           ph == P_HALT};
    act = {bus.pmem_rd_en, bus.pmem_addr, bus.instr,
           bus.instr_valid, pc, busy, halted};
    chk("cycle", 32'(act), 32'(exp));
    if (bus.pmem_rd_en) addr_log.push_back(bus.pmem_addr);
    if (bus.instr_valid) v_log.push_back(bus.instr);
    if (stall && bus.pmem_rd_en) stall_rd++;
  end

  task automatic do_start(input logic [7:0] a);
    @(negedge clk);
    v_log.delete(); addr_log.delete(); stall_rd = 0;
    start = 1'b1; start_pc = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string nm);
    bit got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (halted) begin got = 1; break; end
    end
    chk({nm, "_halt"}, 32'(got), 32'd1);
  endtask

  task automatic wait_byte(input string nm, input logic [7:0] b,
                           output int k);
    bit got = 0;
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.instr_valid && bus.instr == b) begin
        got = 1; k = i; break;
      end
    end
    chk({nm, "_seen"}, 32'(got), 32'd1);
  endtask

  function automatic int count_of(input logic [7:0] b);
    int n = 0;
    foreach (v_log[i]) if (v_log[i] == b) n++;
    return n;
  endfunction

  initial begin
    int k;
    logic [7:0] b;
    for (int a = 0; a < 256; a++) mem[a] = 8'hE0;
    repeat (3) @(negedge clk);
    chk("rst_instr", 32'(bus.instr), 32'h80);
    chk("rst_flags", 32'({bus.instr_valid, bus.pmem_rd_en,
                          busy, halted}), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    rst = 1'b0;

    mem[0] = 8'h01; mem[1] = 8'h25; mem[2] = 8'hE0;
    do_start(8'h00);
    @(negedge clk);
    chk("lat_rd_en", 32'(bus.pmem_rd_en), 32'd1);
    wait_byte("basic01", 8'h01, k);
    chk("lat_first_valid", 32'(k + 1), 32'd3);
    wait_halt("basic");
    chk("basic_n01", 32'(count_of(8'h01)), 32'd1);
    chk("basic_n25", 32'(count_of(8'h25)), 32'd4);
    chk("basic_nvalid", 32'(v_log.size()), 32'd5);
    chk("basic_pc", 32'(pc), 32'd2);
    chk("basic_naddr", 32'(addr_log.size()), 32'd3);
    chk("basic_addrs", 32'({addr_log[0], addr_log[1],
                            addr_log[2]}), 32'h000102);

    mem[5] = 8'h4A; mem[6] = 8'hE0;
    do_start(8'h05);
    wait_halt("rmov");
    chk("rmov_n4a", 32'(count_of(8'h4A)), 32'd2);
    chk("rmov_nvalid", 32'(v_log.size()), 32'd2);
    chk("rmov_pc", 32'(pc), 32'd6);

    do_start(8'h01);
    chk("restart_halted", 32'({halted, busy}), 32'b01);
    wait_halt("restart");
    chk("restart_addr", 32'(addr_log[0]), 32'd1);
    chk("restart_n25", 32'(count_of(8'h25)), 32'd4);

    do_start(8'h01);
    wait_byte("stall25", 8'h25, k);
    @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    wait_halt("stall");
    chk("stall_n25", 32'(count_of(8'h25)), 32'd7);
    chk("stall_no_rd", 32'(stall_rd), 32'd0);

    mem[255] = 8'h60; mem[0] = 8'hE0;
    do_start(8'hFF);
    wait_halt("wrap");
    chk("wrap_valid", 32'({v_log.size() == 1, v_log[0]}), 32'h160);
    chk("wrap_addrs", 32'({addr_log.size() == 2, addr_log[0],
                           addr_log[1]}), 32'h1FF00);
    chk("wrap_pc", 32'(pc), 32'd0);

    do_start(8'h01);
    wait_byte("rstmid25", 8'h25, k);
    start = 1'b1; start_pc = 8'h07;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_pc", 32'({pc, busy}), 32'h03);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_instr", 32'(bus.instr), 32'h80);
    chk("rstmid_flags", 32'({bus.instr_valid, bus.pmem_rd_en,
                             busy, halted}), 32'h0);
    chk("rstmid_pc", 32'(pc), 32'h0);

    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      for (int a = 0; a < 256; a++) begin
        b = 8'($urandom);
        if (b[7:5] == 3'b111 && $urandom_range(0, 3) != 0)
          b[7:5] = 3'($urandom_range(0, 6));
        mem[a] = b;
      end
      start = 1'b1; start_pc = 8'($urandom);
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        start    = ($urandom_range(0, 15) == 0);
        start_pc = 8'($urandom);
        stall    = ($urandom_range(0, 3) == 0);
        rst      = ($urandom_range(0, 299) == 0);
      end
      start = 1'b0; stall = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
Name: instr_issuer

Overview:
- Instruction fetch and issue sequencer. It is the initiator side of the 8-bit instruction bus that the decoder consumes.
- Fetches bytes from a synchronous-read program memory and drives them onto `instr`.
- Holds each instruction for the cycle count the decoder's multi-cycle sequences require: ROM load needs 4 cycles, RMOV needs 2.
- Inserts NOP bubbles between instructions so the decoder's step counters re-arm. Stops on HALT.

Parameters:
- PC_W, 8, program counter / program memory address width.
- ROM_HOLD, 4, issue cycles for opcode 001 (ROM load).
- RMOV_HOLD, 2, issue cycles for opcode 010 (RMOV). Must be even so the decoder's toggle counter returns to its start phase.
- NOP_CODE, 8'h80, byte driven when no instruction is issued. Opcode 100 selects the decoder's default (all enables cleared).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins execution at start_pc. Accepted only in IDLE or HALT.
- start_pc  in  PC_W  first fetch address, sampled with start.
- stall  in  1  freezes issue/fetch progress while high.
- pmem_rd_en  out  1  program memory read strobe.
- pmem_addr  out  PC_W  program memory address.
- pmem_data  in  8  program memory read data, valid the cycle after pmem_rd_en.
- instr  out  8  instruction to decoder.
- instr_valid  out  1  high while instr carries a real (non-bubble) instruction.
- pc  out  PC_W  address of the current/next instruction.
- busy  out  1  high in FETCH, LATCH, ISSUE.
- halted  out  1  high in HALT.

Behaviour:
- All outputs are registered.
- Reset values:
  - pmem_rd_en=0, pmem_addr=0, instr=NOP_CODE, instr_valid=0, pc=0, busy=0, halted=0.
  - state=IDLE, hold_cnt=0.
  - rst takes priority over every other input in any state, including mid-ISSUE.
- States: IDLE, FETCH, LATCH, ISSUE, HALT.
- IDLE:
  - instr=NOP_CODE.
  - start=1 -> pc<=start_pc, go FETCH.
- FETCH:
  - If stall=0: pmem_rd_en=1, pmem_addr=pc, go LATCH.
  - If stall=1: pmem_rd_en=0, remain in FETCH.
  - instr=NOP_CODE.
- LATCH:
  - Capture pmem_data into ir. LATCH is not affected by stall.
  - Opcode ir[7:5]=111 -> go HALT. Nothing is issued and pc is unchanged (points at the HALT byte).
  - Otherwise set hold_cnt and go ISSUE:
    - 001 -> ROM_HOLD.
    - 010 -> RMOV_HOLD.
    - 000, 011, 100, 101, 110 -> 1.
  - instr=NOP_CODE.
- ISSUE:
  - instr=ir, instr_valid=1.
  - Each cycle with stall=0: hold_cnt decrements.
  - Leaving ISSUE: on the cycle hold_cnt reaches 1 with stall=0, set pc<=pc+1 (modulo 2^PC_W; 2^PC_W-1 wraps to 0) and go FETCH.
  - stall=1: hold_cnt and instr are frozen and instr_valid stays 1.
- Instruction period: an instruction with hold H occupies H valid cycles plus 2 NOP cycles (FETCH, LATCH) before the next. Back-to-back ROM loads therefore always see an opcode change, which clears the decoder's step counter.
- HALT:
  - halted=1, busy=0, instr=NOP_CODE.
  - start=1 -> pc<=start_pc, halted<=0, go FETCH.
- start while busy is ignored, with no effect on pc or state.
- Latency: start sampled on edge N.
  - FETCH output (pmem_rd_en=1) is visible after edge N+1.
  - The first valid instr is visible after edge N+3.

Test Plan:
- Basic sequence: pmem[0]=0x01, pmem[1]=0x25, pmem[2]=0xE0; start, start_pc=0.
  - instr=0x01 valid 1 cycle.
  - Then 2 NOP cycles.
  - Then 0x25 valid exactly 4 cycles.
  - Then 2 NOP cycles, then halted=1 with pc=2.
  - pmem_addr sequence 0,1,2.
- RMOV hold: pmem[5]=0x4A, pmem[6]=0xE0, start_pc=5 -> 0x4A valid exactly 2 consecutive cycles, then halted=1, pc=6.
- Stall: during the 2nd ISSUE cycle of 0x25, assert stall for 3 cycles -> 0x25 valid 7 cycles total; no pmem_rd_en asserted during stall.
- Wrap-around: pmem[255]=0x60, pmem[0]=0xE0, start_pc=255 -> 0x60 issued 1 cycle, next pmem_addr=0, halted=1, pc=0.
- Reset mid-ISSUE: rst=1 on the 3rd cycle of the ROM-load hold -> next cycle all outputs at reset values (instr=0x80, instr_valid=0, pc=0, busy=0). start pulses while busy=1 produce no change in pc.
- Restart from HALT: after halting, start with start_pc=1 -> fetch from address 1, halted=0 on the following cycle, 0x25 issued for 4 cycles.
